// File: rtl/gemm_c_writeback_packer_pkg.sv
// gemm_pkg: shared state type, lane geometry and size helper for C write-back
package gemm_pkg;
  typedef enum logic [1:0] {WB_IDLE, WB_RUN, WB_FLUSH, WB_DONE} wb_state_e;
  localparam int OutW = 32;
  localparam int BusW = 128;
  localparam int Lanes = BusW / OutW;
  function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction
endpackage

// File: rtl/gemm_c_writeback_packer_if.sv
// gemm_c_writeback_packer_if: result stream in, SRAM C write port out
interface gemm_c_writeback_packer_if
  import gemm_pkg::*;
#(
  parameter int DW = OutW,
  parameter int BW = BusW,
  parameter int AW = 12
);
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_data;
  logic [AW-1:0] sram_c_addr;
  logic [BW-1:0] sram_c_wdata;
  logic          sram_c_we;
  modport master (output res_valid, res_data, input res_ready, sram_c_addr, sram_c_wdata, sram_c_we);
  modport slave (input res_valid, res_data, output res_ready, sram_c_addr, sram_c_wdata, sram_c_we);
endinterface

// File: rtl/gemm_c_writeback_packer_pack_reg.sv
// wb_pack_reg: lane register that merges beats into a word and emits it registered
module wb_pack_reg #(
  parameter int NL = 4,
  parameter int DW = 32,
  parameter int LW = 2
)(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             wr_i,
  input  logic             emit_i,
  input  logic [LW-1:0]    lane_i,
  input  logic [DW-1:0]    data_i,
  output logic [NL*DW-1:0] word_o,
  output logic             strobe_o
);
  logic [NL-1:0][DW-1:0] pack_q, merged;
  // current pack contents with the incoming beat dropped into its lane
  always_comb begin
    merged = pack_q;
    merged[lane_i] = data_i;
  end
  // accumulate beats; on emit publish the merged word and start the next one empty
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pack_q   <= '0;
      word_o   <= '0;
      strobe_o <= 1'b0;
    end else begin
      strobe_o <= emit_i;
      if (emit_i) word_o <= merged;
      pack_q <= (clr_i || emit_i) ? '0 : wr_i ? merged : pack_q;
    end
  end
endmodule

// File: rtl/gemm_c_writeback_packer.sv
// gemm_c_writeback_packer: packs row-major C results into bus words for SRAM C
module gemm_c_writeback_packer
  import gemm_pkg::*;
#(
  parameter int OutDataWidth  = OutW,
  parameter int C_BusWidth    = BusW,
  parameter int AddrWidth     = 12,
  parameter int SizeAddrWidth = 8,
  parameter int BaseAddr      = 0
)(
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [SizeAddrWidth-1:0] M_size_i,
  input  logic [SizeAddrWidth-1:0] N_size_i,
  gemm_c_writeback_packer_if.slave bus,
  output logic                     busy_o,
  output logic                     done_o
);
  localparam int NL = C_BusWidth / OutDataWidth;
  localparam int LW = NL > 1 ? $clog2(NL) : 1;
  localparam int SW = SizeAddrWidth;
  wb_state_e state_q, state_d;
  logic [SW-1:0] m_q, m_d, n_q, n_d, r_q, r_d, c_q, c_d, stride_q, stride_d;
  logic [AddrWidth-1:0] addr_q;
  logic [2*SW-1:0] addr_full;
  logic [LW-1:0] lane;
  logic fire, last_c, last_r, emit, clr;
  assign fire      = state_q == WB_RUN && bus.res_valid;
  assign last_c    = c_q == n_q - SW'(1);
  assign last_r    = r_q == m_q - SW'(1);
  assign lane      = LW'(c_q % SW'(NL));
  assign emit      = fire && (last_c || lane == LW'(NL - 1));
  assign addr_full = (2*SW)'(BaseAddr) + {{SW{1'b0}}, r_q} * {{SW{1'b0}}, stride_q}
                   + {{SW{1'b0}}, c_q / SW'(NL)};
  // job sequencing and row/column walk over the accepted beats
  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    n_d      = n_q;
    r_d      = r_q;
    c_d      = c_q;
    stride_d = stride_q;
    clr      = 1'b0;
    case (state_q)
      WB_IDLE: if (start_i) begin
        if (M_size_i != '0 && N_size_i != '0) begin
          state_d  = WB_RUN;
          m_d      = M_size_i;
          n_d      = N_size_i;
          stride_d = SW'(ceil_div(32'(N_size_i), 32'(NL)));
          r_d      = '0;
          c_d      = '0;
          clr      = 1'b1;
        end else state_d = WB_DONE;
      end
      WB_RUN: if (fire) begin
        c_d = last_c ? '0 : c_q + SW'(1);
        r_d = last_c ? r_q + SW'(1) : r_q;
        if (last_c && last_r) state_d = WB_FLUSH;
      end
      WB_FLUSH: state_d = WB_DONE;
      default:  state_d = WB_IDLE;
    endcase
  end
  // state, counters and the address of the word being emitted
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= WB_IDLE;
      m_q      <= '0;
      n_q      <= '0;
      r_q      <= '0;
      c_q      <= '0;
      stride_q <= '0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      n_q      <= n_d;
      r_q      <= r_d;
      c_q      <= c_d;
      stride_q <= stride_d;
      if (emit) addr_q <= AddrWidth'(addr_full);
    end
  end
  wb_pack_reg #(.NL(NL), .DW(OutDataWidth), .LW(LW)) u_pack (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (clr),
    .wr_i     (fire),
    .emit_i   (emit),
    .lane_i   (lane),
    .data_i   (bus.res_data),
    .word_o   (bus.sram_c_wdata),
    .strobe_o (bus.sram_c_we)
  );
  assign bus.res_ready   = state_q == WB_RUN;
  assign bus.sram_c_addr = addr_q;
  assign busy_o          = state_q == WB_RUN || state_q == WB_FLUSH;
  assign done_o          = state_q == WB_DONE;
endmodule

// File: tb/tb_gemm_c_writeback_packer.sv
// tb_gemm_c_writeback_packer: directed checks of packing, addressing, timing and reset
module tb_gemm_c_writeback_packer;
  import gemm_pkg::*;
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic start_i = 1'b0;
  logic [7:0] M_size_i = '0;
  logic [7:0] N_size_i = '0;
  logic busy_o, done_o;
  logic clr = 1'b0;
  int total = 0;
  int passed = 0;
  int wcnt = 0;
  int done_cnt = 0;
  int viol = 0;
  int dc;
  logic [127:0] mem [64];
  gemm_c_writeback_packer_if bus ();
  gemm_c_writeback_packer dut (
    .clk_i    (clk),
    .rst_ni   (rst_ni),
    .start_i  (start_i),
    .M_size_i (M_size_i),
    .N_size_i (N_size_i),
    .bus      (bus),
    .busy_o   (busy_o),
    .done_o   (done_o)
  );
  always #5 clk = ~clk;
  // SRAM C model plus done/strobe bookkeeping, sampled mid-cycle
  always @(negedge clk) begin
    if (clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
      wcnt <= 0;
    end else if (bus.sram_c_we) begin
      mem[bus.sram_c_addr[5:0]] <= bus.sram_c_wdata;
      wcnt <= wcnt + 1;
    end
    if (done_o) done_cnt <= done_cnt + 1;
    if (bus.sram_c_we && !busy_o) viol <= viol + 1;
  end
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask
  task automatic clear_mem();
    clr = 1'b1;
    @(negedge clk);
    #1 clr = 1'b0;
  endtask
  task automatic run_job(input int m, input int n, input int gap, input int poke);
    int beat = 0;
    @(negedge clk);
    start_i = 1'b1; M_size_i = 8'(m); N_size_i = 8'(n);
    @(negedge clk);
    start_i = 1'b0;
    for (int r = 0; r < m; r++)
      for (int c = 0; c < n; c++) begin
        chk("ready", bus.res_ready, 1);
        bus.res_valid = 1'b1;
        bus.res_data = 32'(r * 100 + c);
        if (beat == poke) begin start_i = 1'b1; M_size_i = 8'd9; N_size_i = 8'd9; end
        @(negedge clk);
        start_i = 1'b0;
        bus.res_valid = 1'b0;
        beat++;
        if (beat < m * n) repeat (gap) @(negedge clk);
      end
    chk("flush_we", bus.sram_c_we, 1);
    chk("flush_busy", busy_o, 1);
    chk("flush_done", done_o, 0);
    @(negedge clk);
    chk("done_pulse", done_o, 1);
    chk("done_we", bus.sram_c_we, 0);
    @(negedge clk);
    chk("done_end", done_o, 0);
    chk("idle_busy", busy_o, 0);
  endtask
  initial begin
    bus.res_valid = 1'b0;
    bus.res_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", bus.res_ready, 0);
    chk("rst_we", bus.sram_c_we, 0);
    chk("rst_addr", bus.sram_c_addr, 0);
    chk("rst_wdata", bus.sram_c_wdata, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    rst_ni = 1'b1;
    clear_mem();
    run_job(4, 16, 0, -1);
    chk("t1_wcnt", wcnt, 16);
    chk("t1_a0", mem[0], 128'h00000003_00000002_00000001_00000000);
    chk("t1_a1", mem[1], 128'h00000007_00000006_00000005_00000004);
    chk("t1_a4", mem[4], 128'h00000067_00000066_00000065_00000064);
    chk("t1_a15", mem[15], 128'h0000013B_0000013A_00000139_00000138);
    clear_mem();
    run_job(16, 4, 0, -1);
    chk("t2_wcnt", wcnt, 16);
    chk("t2_a0", mem[0], 128'h00000003_00000002_00000001_00000000);
    chk("t2_a7", mem[7], 128'h000002BF_000002BE_000002BD_000002BC);
    chk("t2_a15", mem[15], 128'h000005DF_000005DE_000005DD_000005DC);
    clear_mem();
    run_job(3, 6, 0, -1);
    chk("t3_wcnt", wcnt, 6);
    chk("t3_a1", mem[1], 128'h00000000_00000000_00000005_00000004);
    chk("t3_a4", mem[4], 128'h000000CB_000000CA_000000C9_000000C8);
    chk("t3_a5", mem[5], 128'h00000000_00000000_000000CD_000000CC);
    chk("t3_a6", mem[6], 128'h0);
    clear_mem();
    run_job(2, 3, 2, -1);
    chk("t4_wcnt", wcnt, 2);
    chk("t4_a0", mem[0], 128'h00000000_00000002_00000001_00000000);
    chk("t4_a1", mem[1], 128'h00000000_00000066_00000065_00000064);
    clear_mem();
    @(negedge clk);
    start_i = 1'b1; M_size_i = 8'd0; N_size_i = 8'd5;
    @(negedge clk);
    start_i = 1'b0;
    chk("t5_m0_done", done_o, 1);
    chk("t5_m0_busy", busy_o, 0);
    @(negedge clk);
    chk("t5_m0_done_end", done_o, 0);
    chk("t5_m0_wcnt", wcnt, 0);
    run_job(1, 4, 0, 2);
    chk("t5_poke_wcnt", wcnt, 1);
    chk("t5_poke_a0", mem[0], 128'h00000003_00000002_00000001_00000000);
    clear_mem();
    @(negedge clk);
    start_i = 1'b1; M_size_i = 8'd4; N_size_i = 8'd16;
    @(negedge clk);
    start_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      bus.res_valid = 1'b1;
      bus.res_data = 32'(c);
      @(negedge clk);
    end
    bus.res_valid = 1'b0;
    rst_ni = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    chk("t6_ready", bus.res_ready, 0);
    chk("t6_we", bus.sram_c_we, 0);
    chk("t6_addr", bus.sram_c_addr, 0);
    chk("t6_wdata", bus.sram_c_wdata, 0);
    chk("t6_busy", busy_o, 0);
    chk("t6_done", done_o, 0);
    dc = done_cnt;
    clear_mem();
    repeat (4) @(negedge clk);
    chk("t6_no_done", done_cnt, dc);
    chk("t6_no_write", wcnt, 0);
    run_job(1, 2, 0, -1);
    chk("t6_fresh_wcnt", wcnt, 1);
    chk("t6_fresh_a0", mem[0], 128'h00000000_00000000_00000001_00000000);
    chk("we_outside_busy", viol, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
